// File: rtl/li_add_core_if.sv
// rtl/li_add_core_if.sv - instruction memory bus between the core and a synchronous-read memory
interface li_add_core_if #(
    parameter int ADDR_W = 7
);
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;

    modport master (output imem_addr, input imem_data);
    modport slave  (input imem_addr, output imem_data);
endinterface

// File: rtl/li_add_core.sv
// rtl/li_add_core.sv - multi-cycle RV32I subset core (ADDI, ADD, LUI, EBREAK) with run control and debug read
module li_add_core #(
    parameter int          NUM_REGS = 8,
    parameter int          ADDR_W   = 7,
    parameter logic [31:0] PC_RESET = 32'h0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                run,
    li_add_core_if.master       imem,
    output logic [31:0]         pc_out,
    output logic                halted,
    output logic                illegal,
    output logic [31:0]         retired,
    input  logic [4:0]          dbg_reg_id,
    output logic [31:0]         dbg_reg_value
);
    localparam int          IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [5:0]  NREGS = 6'(NUM_REGS);

    typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, HALT} state_t;

    state_t      state;
    logic [31:0] instr;
    logic [31:0] regs [NUM_REGS];

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd, rs1, rs2;
    logic        is_addi, is_add, is_lui, is_ebreak, legal_op;
    logic [31:0] rs1_val, rs2_val, result;

    function automatic logic in_range(input logic [4:0] id);
        return {1'b0, id} < NREGS;
    endfunction

    // x0 and ids beyond the implemented file both read as zero
    function automatic logic [31:0] reg_read(input logic [4:0] id);
        if (id == 5'd0 || !in_range(id))
            return 32'h0;
        return regs[id[IDX_W-1:0]];
    endfunction

    assign imem.imem_addr = pc_out[ADDR_W+1:2];
    assign dbg_reg_value  = reg_read(dbg_reg_id);

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign is_addi   = (opcode == 7'b0010011) && (funct3 == 3'b000);
    assign is_add    = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
    assign is_lui    = (opcode == 7'b0110111);
    assign is_ebreak = (instr == 32'h00100073);

    assign rs1_val = reg_read(rs1);
    assign rs2_val = reg_read(rs2);

    // Only the register fields an opcode actually uses are range-checked
    always_comb begin
        legal_op = 1'b0;
        result   = 32'h0;
        if (is_addi) begin
            legal_op = in_range(rd) && in_range(rs1);
            result   = rs1_val + {{20{instr[31]}}, instr[31:20]};
        end else if (is_add) begin
            legal_op = in_range(rd) && in_range(rs1) && in_range(rs2);
            result   = rs1_val + rs2_val;
        end else if (is_lui) begin
            legal_op = in_range(rd);
            result   = {instr[31:12], 12'h000};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= FETCH;
            pc_out  <= PC_RESET;
            halted  <= 1'b0;
            illegal <= 1'b0;
            retired <= 32'h0;
            instr   <= 32'h0;
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= 32'h0;
        end else begin
            case (state)
                FETCH: begin
                    if (run)
                        state <= DECODE;
                end
                DECODE: begin
                    instr <= imem.imem_data;
                    state <= EXECUTE;
                end
                EXECUTE: begin
                    if (is_ebreak) begin
                        halted  <= 1'b1;
                        retired <= retired + 32'd1;
                        state   <= HALT;
                    end else if (legal_op) begin
                        if (rd != 5'd0)
                            regs[rd[IDX_W-1:0]] <= result;
                        pc_out  <= pc_out + 32'd4;
                        retired <= retired + 32'd1;
                        state   <= FETCH;
                    end else begin
                        halted  <= 1'b1;
                        illegal <= 1'b1;
                        state   <= HALT;
                    end
                end
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end
endmodule
